// File: rtl/cache_miss_arb_fsm_if.sv
// ----------------------------------------------------------------------------
// cache_miss_arb_fsm_if
// Purpose : bundles the per-port cache status, AXI handshake and perf counter
//           signals of the shared miss-handling controller.
// Params  : NUM_PORTS - number of cache ports, CNT_W - perf counter width.
// Signals : hit_i/dirty_i/req_i/kill_i [NUM_PORTS]  cache port status
//           axi_done_i                             AXI transaction complete
//           stall_o [NUM_PORTS], stall_any_o       pipeline stalls
//           cache_we_o [NUM_PORTS]                 one-hot refill write enable
//           axi_write_start_o/axi_read_start_o     AXI requests
//           axi_port_o [IDX_W]                     granted port index
//           busy_o                                 controller not idle
//           miss_cnt_o [NUM_PORTS*CNT_W], wb_cnt_o perf counters
// Modports: slave  - the controller side
//           master - the cache/AXI environment side
// ----------------------------------------------------------------------------
interface cache_miss_arb_fsm_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned CNT_W     = 32
);
  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]       hit_i;
  logic [NUM_PORTS-1:0]       dirty_i;
  logic [NUM_PORTS-1:0]       req_i;
  logic [NUM_PORTS-1:0]       kill_i;
  logic                       axi_done_i;
  logic [NUM_PORTS-1:0]       stall_o;
  logic                       stall_any_o;
  logic [NUM_PORTS-1:0]       cache_we_o;
  logic                       axi_write_start_o;
  logic                       axi_read_start_o;
  logic [IDX_W-1:0]           axi_port_o;
  logic                       busy_o;
  logic [NUM_PORTS*CNT_W-1:0] miss_cnt_o;
  logic [CNT_W-1:0]           wb_cnt_o;

  modport slave (
    input  hit_i, dirty_i, req_i, kill_i, axi_done_i,
    output stall_o, stall_any_o, cache_we_o, axi_write_start_o,
           axi_read_start_o, axi_port_o, busy_o, miss_cnt_o, wb_cnt_o
  );

  modport master (
    output hit_i, dirty_i, req_i, kill_i, axi_done_i,
    input  stall_o, stall_any_o, cache_we_o, axi_write_start_o,
           axi_read_start_o, axi_port_o, busy_o, miss_cnt_o, wb_cnt_o
  );
endinterface

// File: rtl/cache_miss_arb_fsm.sv
// ----------------------------------------------------------------------------
// cache_miss_arb_fsm
// Purpose : miss-handling controller shared by NUM_PORTS cache ports. A
//           round-robin arbiter picks one missing port, optionally writes back
//           its dirty victim, refills it over the single AXI4-Lite master and
//           stalls the pipeline while any miss is unresolved.
// Ports   : clk_i  - clock
//           arst_i - asynchronous active-high reset
//           bus    - cache_miss_arb_fsm_if.slave (cache status, AXI handshake,
//                    stalls, refill write enable, perf counters)
// Config  : define CACHE_MISS_PERF_EN to build the per-port refill counters
//           and the write-back counter; otherwise those outputs are tied to 0.
// ----------------------------------------------------------------------------
module cache_miss_arb_fsm #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  cache_miss_arb_fsm_if.slave  bus
);
  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int          NP_I  = int'(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0] miss_c, pend_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic                 win_dirty_c;
  logic [NUM_PORTS-1:0] stall_c, cache_we_c;
  logic                 wr_start_c, rd_start_c, busy_c;

  // pend ignores kill (used while busy); miss honours kill (used in IDLE)
  assign pend_c = bus.req_i & ~bus.hit_i;
  assign miss_c = pend_c & ~bus.kill_i;

  // Round-robin pick: the missing port closest to rr_ptr going upward (mod N)
  always_comb begin
    int d;
    int best;
    d           = 0;
    best        = NP_I;
    win_idx_c   = rr_ptr_q;
    win_dirty_c = 1'b0;
    for (int i = 0; i < NP_I; i++) begin
      d = (i >= int'(rr_ptr_q)) ? (i - int'(rr_ptr_q)) : (i + NP_I - int'(rr_ptr_q));
      if (miss_c[i] && (d < best)) begin
        best        = d;
        win_idx_c   = IDX_W'(i);
        win_dirty_c = bus.dirty_i[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|miss_c) begin
          grant_d = win_idx_c;
          state_d = win_dirty_c ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (bus.axi_done_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (bus.axi_done_i) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; stalls and starts react to inputs in the same cycle
  always_comb begin
    stall_c    = '0;
    cache_we_c = '0;
    wr_start_c = 1'b0;
    rd_start_c = 1'b0;
    busy_c     = (state_q != IDLE);
    case (state_q)
      IDLE: stall_c = miss_c;
      WRITE_BACK: begin
        wr_start_c = ~bus.axi_done_i;
        for (int i = 0; i < NP_I; i++)
          stall_c[i] = (grant_q == IDX_W'(i)) | pend_c[i];
      end
      ALLOCATE: begin
        rd_start_c = ~bus.axi_done_i;
        for (int i = 0; i < NP_I; i++) begin
          stall_c[i]    = (grant_q == IDX_W'(i)) | pend_c[i];
          cache_we_c[i] = (grant_q == IDX_W'(i)) & bus.axi_done_i;
        end
      end
      default: stall_c = miss_c;
    endcase
  end

  assign bus.stall_o           = stall_c;
  assign bus.stall_any_o       = |stall_c;
  assign bus.cache_we_o        = cache_we_c;
  assign bus.axi_write_start_o = wr_start_c;
  assign bus.axi_read_start_o  = rd_start_c;
  assign bus.axi_port_o        = grant_q;
  assign bus.busy_o            = busy_c;

`ifdef CACHE_MISS_PERF_EN
  logic [NUM_PORTS*CNT_W-1:0] miss_cnt_q;
  logic [CNT_W-1:0]           wb_cnt_q;

  // Perf counters: refills per port and completed write-backs (wrapping)
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NP_I; i++) begin
        if (cache_we_c[i])
          miss_cnt_q[i*CNT_W +: CNT_W] <= miss_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
      if ((state_q == WRITE_BACK) && bus.axi_done_i)
        wb_cnt_q <= wb_cnt_q + CNT_W'(1);
    end
  end

  assign bus.miss_cnt_o = miss_cnt_q;
  assign bus.wb_cnt_o   = wb_cnt_q;
`else
  assign bus.miss_cnt_o = '0;
  assign bus.wb_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_cache_miss_arb_fsm.sv
// ----------------------------------------------------------------------------
// tb_cache_miss_arb_fsm
// Purpose : scoreboard bench for cache_miss_arb_fsm with four ports. The driver
//           walks each miss transaction procedurally (idle cycle, optional
//           write-back, refill) and pushes the expected outputs of every cycle;
//           a monitor pops and compares them on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_cache_miss_arb_fsm;
  localparam int unsigned NP = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  cache_miss_arb_fsm_if #(.NUM_PORTS(NP), .CNT_W(CW)) bus ();
  cache_miss_arb_fsm #(.NUM_PORTS(NP), .CNT_W(CW)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus)
  );

  typedef struct {
    logic [NP-1:0]    stall;
    logic [NP-1:0]    we;
    logic             wr;
    logic             rd;
    logic             busy;
    logic [IW-1:0]    port;
    logic [NP*CW-1:0] mcnt;
    logic [CW-1:0]    wcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: last granted port, next preferred port, counters
  int          m_grant = 0;
  int          m_rr    = 0;
  logic [CW-1:0] m_mcnt [NP];
  logic [CW-1:0] m_wcnt;

  function automatic void model_reset();
    m_grant = 0;
    m_rr    = 0;
    m_wcnt  = '0;
    for (int i = 0; i < int'(NP); i++) m_mcnt[i] = '0;
  endfunction

  function automatic void push(input logic [NP-1:0] stall, input logic [NP-1:0] we,
                               input logic wr, input logic rd, input logic busy);
    exp_t e;
    e.stall = stall;
    e.we    = we;
    e.wr    = wr;
    e.rd    = rd;
    e.busy  = busy;
    e.port  = IW'(m_grant);
`ifdef CACHE_MISS_PERF_EN
    for (int i = 0; i < int'(NP); i++) e.mcnt[i*CW +: CW] = m_mcnt[i];
    e.wcnt = m_wcnt;
`else
    e.mcnt = '0;
    e.wcnt = '0;
`endif
    exp_q.push_back(e);
  endfunction

  // First missing port at or after m_rr, wrapping around
  function automatic int pick(input logic [NP-1:0] miss);
    for (int k = 0; k < int'(NP); k++) begin
      int j;
      j = (m_rr + k) % int'(NP);
      if (miss[j]) return j;
    end
    return m_rr;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall_o",           64'(bus.stall_o),           64'(e.stall));
      chk("stall_any_o",       64'(bus.stall_any_o),       64'(|e.stall));
      chk("cache_we_o",        64'(bus.cache_we_o),        64'(e.we));
      chk("axi_write_start_o", 64'(bus.axi_write_start_o), 64'(e.wr));
      chk("axi_read_start_o",  64'(bus.axi_read_start_o),  64'(e.rd));
      chk("busy_o",            64'(bus.busy_o),            64'(e.busy));
      chk("axi_port_o",        64'(bus.axi_port_o),        64'(e.port));
      chk("miss_cnt_o",        64'(bus.miss_cnt_o),        64'(e.mcnt));
      chk("wb_cnt_o",          64'(bus.wb_cnt_o),          64'(e.wcnt));
    end
  end

  task automatic drive(input logic [NP-1:0] req, input logic [NP-1:0] hit,
                       input logic [NP-1:0] dirty, input logic [NP-1:0] kill,
                       input logic done, input logic rst);
    @(posedge clk);
    #1;
    arst           = rst;
    bus.req_i      = req;
    bus.hit_i      = hit;
    bus.dirty_i    = dirty;
    bus.kill_i     = kill;
    bus.axi_done_i = done;
  endtask

  // One busy-phase cycle; inputs either held or randomised
  task automatic busy_cycle(input logic [NP-1:0] req, input logic [NP-1:0] hit,
                            input logic [NP-1:0] bkill, input bit rnd, input logic done,
                            input bit alloc);
    logic [NP-1:0] r, h, k, oh;
    r  = rnd ? NP'($urandom) : req;
    h  = rnd ? NP'($urandom) : hit;
    k  = rnd ? NP'($urandom) : bkill;
    oh = NP'(1) << m_grant;
    drive(r, h, NP'($urandom), k, done, 1'b0);
    push(oh | (r & ~h), (alloc && done) ? oh : '0, !alloc && !done, alloc && !done, 1'b1);
  endtask

  // Full miss transaction starting from IDLE
  task automatic run_txn(input logic [NP-1:0] req, input logic [NP-1:0] hit,
                         input logic [NP-1:0] dirty, input logic [NP-1:0] kill,
                         input logic [NP-1:0] bkill, input bit rnd,
                         input int wb_lat, input int rd_lat);
    logic [NP-1:0] miss;
    int w;
    drive(req, hit, dirty, kill, 1'($urandom), 1'b0);
    miss = req & ~hit & ~kill;
    push(miss, '0, 1'b0, 1'b0, 1'b0);
    if (miss == '0) return;
    w       = pick(miss);
    m_grant = w;
    if (dirty[w]) begin
      for (int c = 0; c <= wb_lat; c++) busy_cycle(req, hit, bkill, rnd, c == wb_lat, 1'b0);
      m_wcnt = m_wcnt + CW'(1);
    end
    for (int c = 0; c <= rd_lat; c++) busy_cycle(req, hit, bkill, rnd, c == rd_lat, 1'b1);
    m_mcnt[w] = m_mcnt[w] + CW'(1);
    m_rr      = (w + 1) % int'(NP);
  endtask

  initial begin
    model_reset();
    bus.req_i = '0; bus.hit_i = '0; bus.dirty_i = '0; bus.kill_i = '0; bus.axi_done_i = 1'b0;

    // Reset held with a pending miss: IDLE stall equation, all else 0
    drive(4'b0000, '0, '0, '0, 1'b0, 1'b1); push('0, '0, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, '0, '0, '0, 1'b1, 1'b1); push(4'b0001, '0, 1'b0, 1'b0, 1'b0);
    drive(4'b0000, '0, '0, '0, 1'b0, 1'b0); push('0, '0, 1'b0, 1'b0, 1'b0);

    // Clean miss on port 0, done after five read cycles
    run_txn(4'b0001, '0, '0, '0, '0, 1'b0, 0, 5);
    // Dirty miss on port 1
    run_txn(4'b0010, '0, 4'b0010, '0, '0, 1'b0, 3, 4);
    // Ports 0 and 1 both missing: three rounds alternate 0,1
    repeat (6) run_txn(4'b0011, '0, '0, '0, '0, 1'b0, 1, 2);
    // Kill in IDLE suppresses the miss; kill while allocating is ignored
    run_txn(4'b0001, '0, '0, 4'b0001, '0, 1'b0, 0, 0);
    run_txn(4'b0001, '0, 4'b0001, '0, 4'b0001, 1'b0, 2, 3);
    // After port 2 wins, port 3 precedes port 1
    run_txn(4'b0100, '0, '0, '0, '0, 1'b0, 0, 1);
    run_txn(4'b1010, '0, '0, '0, '0, 1'b0, 0, 1);
    run_txn(4'b1010, '0, '0, '0, '0, 1'b0, 0, 1);

    // Reset pulse in the middle of a write-back
    drive(4'b0010, '0, 4'b0010, '0, 1'b0, 1'b0); push(4'b0010, '0, 1'b0, 1'b0, 1'b0);
    m_grant = 1;
    busy_cycle(4'b0010, '0, '0, 1'b0, 1'b0, 1'b0);
    busy_cycle(4'b0010, '0, '0, 1'b0, 1'b0, 1'b0);
    drive(4'b0010, '0, 4'b0010, '0, 1'b0, 1'b1);
    model_reset();
    push(4'b0010, '0, 1'b0, 1'b0, 1'b0);
    drive(4'b0000, '0, '0, '0, 1'b0, 1'b0); push('0, '0, 1'b0, 1'b0, 1'b0);
    // Pointer back at 0 after reset
    run_txn(4'b1001, '0, '0, '0, '0, 1'b0, 0, 1);

    // Randomised traffic
    repeat (150) begin
      run_txn(NP'($urandom), NP'($urandom), NP'($urandom), NP'($urandom & $urandom),
              '0, 1'b1, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
